dbus_bridge: RTL and testbench

DBUS_BRIDGE -- requirements
Module: dbus_bridge

---
 rtl/dbus_bridge.sv | 169 ++++++++++++++++
 tb/tb_dbus_bridge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_bridge.sv
// Core data-memory port to Wishbone bridge: one access at a time, with byte-lane steering,
// load extension, bus-error/timeout reporting and a result hold while the core is frozen.

module dbus_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        sel,
  output logic [7:0]  wbyte
);
  localparam logic [1:0] LN = 2'(LANE);

  always_comb begin
    sel   = 1'b0;
    wbyte = wdata[8*LANE +: 8];
    case (size)
      2'b00: begin sel = (off == LN);       wbyte = wdata[7:0];              end
      2'b01: begin sel = (off[1] == LN[1]); wbyte = wdata[8*(LANE%2) +: 8];  end
      2'b10: begin sel = 1'b1;              wbyte = wdata[8*LANE +: 8];      end
      default: ;
    endcase
  end
endmodule

module dbus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [1:0]  mem_type,
  input  logic        mem_ext,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  input  logic        dc_lock,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_unalign,
  output logic        mem_bus_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [29:0] wb_addr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dout,
  input  logic [31:0] wb_din,
  input  logic        wb_ack,
  input  logic        wb_err
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       ext;
  } req_t;

  state_t state;
  req_t   req_q;
  logic [7:0] cnt;
  logic       err_q;

  logic req, misalign;
  logic [NUM_LANES-1:0]       sel_c;
  logic [NUM_LANES-1:0][7:0]  wdat_c;
  logic [31:0] rd_shift, rd_ext;
  logic [7:0]  cnt_inc;

  assign req      = mem_ren | mem_wen;
  assign misalign = (mem_type == 2'b11) ||
                    (mem_type == 2'b01 && mem_addr[0]) ||
                    (mem_type == 2'b10 && (mem_addr[1:0] != 2'b00));
  assign cnt_inc  = cnt + 8'd1;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    dbus_lane #(.LANE(g)) u_lane (
      .size  (mem_type),
      .off   (mem_addr[1:0]),
      .wdata (mem_dout),
      .sel   (sel_c[g]),
      .wbyte (wdat_c[g])
    );
  end

  // Move the addressed lane(s) down to bit 0, then extend by access size.
  assign rd_shift = wb_din >> {req_q.off, 3'b000};
  always_comb begin
    rd_ext = rd_shift;
    case (req_q.size)
      2'b00:   rd_ext = {{24{req_q.ext & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   rd_ext = {{16{req_q.ext & rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_comb begin
    mem_stall   = 1'b0;
    mem_unalign = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          mem_stall   = req & ~misalign;
          mem_unalign = req & misalign;
        end
        BUSY:    mem_stall = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_bus_err = (state == DONE) & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      mem_din <= '0;
      wb_cyc  <= 1'b0;
      wb_stb  <= 1'b0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_sel  <= '0;
      wb_dout <= '0;
    end else begin
      case (state)
        IDLE: if (req && !misalign) begin
          state   <= BUSY;
          req_q   <= '{off: mem_addr[1:0], size: mem_type, ext: mem_ext};
          cnt     <= '0;
          err_q   <= 1'b0;
          mem_din <= '0;
          wb_cyc  <= 1'b1;
          wb_stb  <= 1'b1;
          wb_we   <= mem_wen;
          wb_addr <= mem_addr[31:2];
          wb_sel  <= sel_c;
          wb_dout <= wdat_c;
        end
        BUSY: begin
          // Error beats ack when both arrive; ack beats a coincident timeout.
          if (wb_err || (!wb_ack && cnt_inc == 8'(TIMEOUT))) begin
            state   <= DONE;
            err_q   <= 1'b1;
            mem_din <= '0;
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
          end else if (wb_ack) begin
            state   <= DONE;
            mem_din <= wb_we ? 32'h0 : rd_ext;
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        DONE: if (!dc_lock) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbus_bridge.sv
// Directed bench for dbus_bridge: a vector table of single accesses plus hand sequences
// for reset, dc_lock hold and reset during a bus cycle.

module tb_dbus_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen, mem_ext, dc_lock;
  logic [1:0]  mem_type;
  logic [31:0] mem_addr, mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall, mem_unalign, mem_bus_err;
  logic        wb_cyc, wb_stb, wb_we;
  logic [29:0] wb_addr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dout, wb_din;
  logic        wb_ack, wb_err;

  int checks = 0;
  int errors = 0;
  int stb_rises = 0;
  logic stb_d = 1'b0;

  dbus_bridge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_type(mem_type), .mem_ext(mem_ext),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .dc_lock(dc_lock),
    .mem_din(mem_din), .mem_stall(mem_stall), .mem_unalign(mem_unalign),
    .mem_bus_err(mem_bus_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_sel(wb_sel), .wb_dout(wb_dout), .wb_din(wb_din),
    .wb_ack(wb_ack), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    stb_d <= wb_stb;
    if (wb_stb && !stb_d) stb_rises <= stb_rises + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    mem_ren = 1'b0; mem_wen = 1'b0; mem_type = 2'b00; mem_ext = 1'b0;
    mem_addr = '0; mem_dout = '0;
  endtask

  typedef struct {
    logic        ren, wen;
    logic [1:0]  typ;
    logic        ext;
    logic [31:0] addr, dout, wbdin;
    int          ack_at;      // BUSY cycle index carrying ack/err; -1 = never
    logic        a, e;
    logic        unal;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdo, din;
    logic        berr;
    int          busy;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{1'b1,1'b0,2'b00,1'b1,32'h1003,32'h0,32'h80FFFF7F, 0,1'b1,1'b0, 1'b0,4'b1000,1'b0,32'h0,32'hFFFFFF80,1'b0,1};
    vt[1]  = '{1'b0,1'b1,2'b01,1'b0,32'h2002,32'h0000BEEF,32'h0, 2,1'b1,1'b0, 1'b0,4'b1100,1'b1,32'hBEEFBEEF,32'h0,1'b0,3};
    vt[2]  = '{1'b1,1'b0,2'b10,1'b0,32'h3001,32'h0,32'h0, 0,1'b1,1'b0, 1'b1,4'b0000,1'b0,32'h0,32'h0,1'b0,0};
    vt[3]  = '{1'b1,1'b0,2'b10,1'b0,32'h4000,32'h0,32'h12345678, -1,1'b0,1'b0, 1'b0,4'b1111,1'b0,32'h0,32'h0,1'b1,4};
    vt[4]  = '{1'b1,1'b0,2'b01,1'b0,32'h5002,32'h0,32'h80011234, 1,1'b1,1'b0, 1'b0,4'b1100,1'b0,32'h0,32'h00008001,1'b0,2};
    vt[5]  = '{1'b1,1'b0,2'b01,1'b1,32'h5000,32'h0,32'h80018234, 0,1'b1,1'b0, 1'b0,4'b0011,1'b0,32'h0,32'hFFFF8234,1'b0,1};
    vt[6]  = '{1'b1,1'b0,2'b10,1'b1,32'h6004,32'h0,32'hDEADBEEF, 0,1'b1,1'b0, 1'b0,4'b1111,1'b0,32'h0,32'hDEADBEEF,1'b0,1};
    vt[7]  = '{1'b1,1'b0,2'b00,1'b0,32'h7001,32'h0,32'hFFFFFFFF, 1,1'b0,1'b1, 1'b0,4'b0010,1'b0,32'h0,32'h0,1'b1,2};
    vt[8]  = '{1'b0,1'b1,2'b00,1'b0,32'h8002,32'h000000A5,32'h0, 0,1'b1,1'b1, 1'b0,4'b0100,1'b1,32'hA5A5A5A5,32'h0,1'b1,1};
    vt[9]  = '{1'b1,1'b1,2'b10,1'b0,32'h9000,32'h12345678,32'hFFFFFFFF, 0,1'b1,1'b0, 1'b0,4'b1111,1'b1,32'h12345678,32'h0,1'b0,1};
    vt[10] = '{1'b1,1'b0,2'b11,1'b0,32'hA000,32'h0,32'h0, 0,1'b1,1'b0, 1'b1,4'b0000,1'b0,32'h0,32'h0,1'b0,0};
    vt[11] = '{1'b0,1'b1,2'b01,1'b0,32'hB001,32'h0,32'h0, 0,1'b1,1'b0, 1'b1,4'b0000,1'b0,32'h0,32'h0,1'b0,0};
    vt[12] = '{1'b1,1'b0,2'b00,1'b0,32'h1000,32'h0,32'h000000F0, 0,1'b1,1'b0, 1'b0,4'b0001,1'b0,32'h0,32'h000000F0,1'b0,1};

    idle_in();
    dc_lock = 1'b0; wb_din = '0; wb_ack = 1'b0; wb_err = 1'b0;

    // Reset state; a request held during reset must not stall or flag.
    rst = 1'b1;
    tick();
    mem_ren = 1'b1; mem_type = 2'b10; mem_addr = 32'h3001; #1;
    chk("rst_unalign", {31'b0, mem_unalign}, 32'h0);
    mem_addr = 32'h3000; #1;
    chk("rst_stall", {31'b0, mem_stall}, 32'h0);
    tick();
    chk("rst_cyc_stb_we", {29'b0, wb_cyc, wb_stb, wb_we}, 32'h0);
    chk("rst_addr", {2'b0, wb_addr}, 32'h0);
    chk("rst_sel", {28'b0, wb_sel}, 32'h0);
    chk("rst_dout", wb_dout, 32'h0);
    chk("rst_din", mem_din, 32'h0);
    chk("rst_bus_err", {31'b0, mem_bus_err}, 32'h0);
    idle_in();
    rst = 1'b0;
    tick();

    foreach (vt[i]) begin
      automatic vec_t v = vt[i];
      automatic int bc = 0;
      wb_din = v.wbdin;
      mem_ren = v.ren; mem_wen = v.wen; mem_type = v.typ; mem_ext = v.ext;
      mem_addr = v.addr; mem_dout = v.dout;
      #1;
      chk($sformatf("v%0d_unalign", i), {31'b0, mem_unalign}, {31'b0, v.unal});
      chk($sformatf("v%0d_stall_idle", i), {31'b0, mem_stall}, {31'b0, ~v.unal});
      if (v.unal) begin
        tick();
        chk($sformatf("v%0d_no_cyc", i), {31'b0, wb_cyc}, 32'h0);
        idle_in();
        tick();
        continue;
      end
      tick();
      chk($sformatf("v%0d_cyc_stb", i), {30'b0, wb_cyc, wb_stb}, 32'h3);
      chk($sformatf("v%0d_we", i), {31'b0, wb_we}, {31'b0, v.we});
      chk($sformatf("v%0d_sel", i), {28'b0, wb_sel}, {28'b0, v.sel});
      chk($sformatf("v%0d_addr", i), {2'b0, wb_addr}, {2'b0, v.addr[31:2]});
      if (v.we) chk($sformatf("v%0d_wdata", i), wb_dout, v.wdo);
      idle_in();
      while (mem_stall && bc < 20) begin
        if (bc == v.ack_at) begin wb_ack = v.a; wb_err = v.e; end
        tick();
        wb_ack = 1'b0; wb_err = 1'b0;
        bc++;
      end
      chk($sformatf("v%0d_busy_cycles", i), bc, v.busy);
      chk($sformatf("v%0d_din", i), mem_din, v.din);
      chk($sformatf("v%0d_bus_err", i), {31'b0, mem_bus_err}, {31'b0, v.berr});
      chk($sformatf("v%0d_cyc_done", i), {31'b0, wb_cyc}, 32'h0);
      tick();
      chk($sformatf("v%0d_cyc_after", i), {31'b0, wb_cyc}, 32'h0);
    end

    // dc_lock hold in DONE with the request still presented by the frozen core.
    begin
      automatic int rises0;
      automatic int bc = 0;
      rises0 = stb_rises;
      wb_din = 32'h00000055;
      mem_ren = 1'b1; mem_type = 2'b00; mem_addr = 32'h0; mem_ext = 1'b1;
      tick();
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      dc_lock = 1'b1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("lock%0d_din", k), mem_din, 32'h55);
        chk($sformatf("lock%0d_stall", k), {31'b0, mem_stall}, 32'h0);
        chk($sformatf("lock%0d_stb", k), {31'b0, wb_stb}, 32'h0);
        tick();
      end
      dc_lock = 1'b0;
      idle_in();
      tick();
      chk("lock_one_txn", stb_rises - rises0, 1);
      mem_ren = 1'b1; mem_type = 2'b10; mem_addr = 32'h1; #1;
      chk("lock_back_idle", {31'b0, mem_unalign}, 32'h1);
      idle_in();
      tick();

      // Reset in the second BUSY cycle, late ack one cycle after.
      wb_din = 32'hCAFEF00D;
      mem_ren = 1'b1; mem_type = 2'b10; mem_addr = 32'h100;
      tick();
      idle_in();
      tick();
      rst = 1'b1; #1;
      chk("rstbusy_stall", {31'b0, mem_stall}, 32'h0);
      tick();
      rst = 1'b0;
      wb_ack = 1'b1;
      tick();
      wb_ack = 1'b0;
      chk("rstbusy_cyc", {31'b0, wb_cyc}, 32'h0);
      chk("rstbusy_bus_err", {31'b0, mem_bus_err}, 32'h0);
      chk("rstbusy_din", mem_din, 32'h0);
      chk("rstbusy_stall_after", {31'b0, mem_stall}, 32'h0);
      while (wb_cyc && bc < 10) begin tick(); bc++; end
      mem_ren = 1'b1; mem_type = 2'b01; mem_addr = 32'h1; #1;
      chk("rstbusy_idle", {31'b0, mem_unalign}, 32'h1);
      idle_in();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
